int_desel: RTL and testbench
============================

// Module: int_desel
// PURPOSE
//  Inverse of the exponent-range index selector. Takes a range index i (1..11) and
//  a normalized 11-bit mantissa, and rebuilds the 15-bit data word by shifting
//  right by (i-1), one bit per clock, with optional round-half-up.
//  Sits on the output side of the ex calculation datapath, after mantissa evaluation.
//  Valid/ready handshake on both sides; one transaction in flight.
// PARAMETERS
//  DATA_W   15  output data width; bits [DATA_W-1:MANT_W] are always 0
//  MANT_W   11  mantissa width
//  IDX_MAX  11  largest legal index
//  ROUND    1   1 = round half-up on the last shifted-out bit; 0 = truncate
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       input transaction present
//  in_ready   out  1       block can accept (high only in IDLE, low while rst=1)
//  i          in   5       range index, legal 1..IDX_MAX
//  mant       in   MANT_W  mantissa; mant[10] need not be 1 (no check)
//  out_valid  out  1       data/err valid
//  out_ready  in   1       downstream accepts
//  data       out  DATA_W  reconstructed value = mant >> (i-1), rounded per ROUND
//  err        out  1       illegal index seen (i==0 or i>IDX_MAX)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, out_valid=0, data=0, err=0, counter=0.
//    Reset mid-transaction abandons it; no out_valid for the abandoned transaction.
//  - FSM states:
//    IDLE: in_ready=1. On in_valid: latch mant into the shift reg, cnt=i-1, clear sticky.
//      i==0 or i>IDX_MAX -> OUT with data=0, err=1.
//      i==1 -> OUT with data=mant.
//      otherwise -> SHIFT.
//    SHIFT: per cycle: shreg>>=1, lastbit=shreg[0], cnt--.
//      When cnt==1 this cycle (final shift) -> OUT.
//    OUT: out_valid=1. data/err are held stable until out_ready=1, then -> IDLE.
//  - Latency from accept edge to out_valid=1 is i cycles for legal i, 1 cycle for
//    illegal i. Throughput: one transaction per latency+1 cycles at minimum.
//  - Rounding (ROUND=1): data = shifted + lastbit, applied on entry to OUT.
//    No overflow: any shift >=1 gives <=1023, so the result is <=1024. i==1 is never rounded.
//  - data[DATA_W-1:MANT_W] = 0 always. err=0 on every legal transaction.
//  - Inputs are ignored outside IDLE. in_valid and out_ready are sampled only in
//    their own states, so simultaneous assertion has no interaction.
//  - out_valid drops the cycle after the handoff. data keeps its last value until
//    the next OUT entry.
// TESTING
//  1. i=1, mant=2047 -> out_valid 1 cycle after accept, data=2047, err=0.
//  2. i=4, mant=1500, ROUND=1 -> data=188 at latency 4. With ROUND=0 -> data=187.
//  3. i=11, mant=1535 -> data=1. i=11, mant=1536 -> data=2 (ROUND=1), latency 11.
//  4. i=0, then i=12 (any mant) -> data=0, err=1, latency 1. Next legal txn has err=0.
//  5. i=2, mant=1000, out_ready low 5 cycles -> data=500 stable, in_ready=0
//     throughout. Handoff on out_ready=1, then in_ready=1 the next cycle.
//  6. i=8 accepted, rst=1 on 3rd SHIFT cycle -> no out_valid, outputs 0.
//     Then i=3, mant=1024 -> data=256.

Source files
------------

// File: rtl/int_desel.sv
// int_desel: rebuilds a DATA_W-bit data word from a range index and a
// normalized mantissa by shifting the mantissa right by (i-1), one bit per
// clock, with optional round-half-up on the last bit shifted out.
// Valid/ready handshake on both sides, one transaction in flight.
module int_desel #(
  parameter int DATA_W  = 15,
  parameter int MANT_W  = 11,
  parameter int IDX_MAX = 11,
  parameter int ROUND   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        i,
  input  logic [MANT_W-1:0] mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_OUT
  } state_t;

  localparam logic [4:0] IDX_MAX_L = 5'(IDX_MAX);

  state_t              r_state;
  logic [MANT_W-1:0]   r_shreg;
  logic [4:0]          r_cnt;
  logic                r_out_valid;
  logic [MANT_W-1:0]   r_data;
  logic                r_err;

  logic                w_illegal;
  logic [MANT_W-1:0]   w_shifted;
  logic                w_round_bit;
  logic [MANT_W-1:0]   w_rounded;

  // Index legality check on the incoming request.
  assign w_illegal = (i == 5'd0) || (i > IDX_MAX_L);

  // One-bit shift of the working register; the bit falling off is the rounding bit.
  // The top bit of w_shifted is always 0, so adding the round bit cannot overflow.
  assign w_shifted   = {1'b0, r_shreg[MANT_W-1:1]};
  assign w_round_bit = (ROUND != 0) ? r_shreg[0] : 1'b0;
  assign w_rounded   = w_shifted + {{(MANT_W-1){1'b0}}, w_round_bit};

  // Ready only while idle and not being reset.
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign data      = {{(DATA_W-MANT_W){1'b0}}, r_data};
  assign err       = r_err;

  // Control FSM with registered outputs: accept, shift (i-1) times, present result.
  always_ff @(posedge clk) begin
    // NOTE: every register here is assigned with <= so all updates see the
    // pre-edge values of each other, exactly like the flops they model.
    if (rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shreg <= mant;
            r_cnt   <= i - 5'd1;
            if (w_illegal) begin
              r_data      <= '0;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else if (i == 5'd1) begin
              // No shift, so nothing to round.
              r_data      <= mant;
              r_err       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          r_shreg <= w_shifted;
          r_cnt   <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            // Final shift: the result and its rounding are captured together.
            r_data      <= w_rounded;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_desel.sv
// Testbench for int_desel: directed cases with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model
// that predicts the result value and the latency of each transaction.
module tb_int_desel;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  i;
  logic [10:0] mant;
  logic        out_ready;

  logic        in_ready_r, out_valid_r, err_r;
  logic [14:0] data_r;
  logic        in_ready_t, out_valid_t, err_t;
  logic [14:0] data_t;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int_desel #(.ROUND(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .i(i), .mant(mant), .out_valid(out_valid_r), .out_ready(out_ready),
    .data(data_r), .err(err_r)
  );

  int_desel #(.ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .i(i), .mant(mant), .out_valid(out_valid_t), .out_ready(out_ready),
    .data(data_t), .err(err_t)
  );

  // ---------------- behavioural model ----------------
  bit model_ok = 1'b0;
  bit m_busy, m_ov, m_err, p_err;
  int m_wait, m_data_r, m_data_t, p_r, p_t;

  function automatic int ref_data(input int ii, input int mm, input bit rnd);
    int r;
    if (ii == 0 || ii > 11) return 0;
    if (ii == 1) return mm;
    r = mm >> (ii - 1);
    if (rnd) r = r + ((mm >> (ii - 2)) & 1);
    return r;
  endfunction

  task automatic publish();
    m_ov     = 1'b1;
    m_data_r = p_r;
    m_data_t = p_t;
    m_err    = p_err;
  endtask

  task automatic model_update();
    if (rst) begin
      model_ok = 1'b1;
      m_busy = 1'b0; m_ov = 1'b0; m_err = 1'b0;
      m_data_r = 0; m_data_t = 0; m_wait = 0;
    end else if (model_ok) begin
      if (m_ov) begin
        if (out_ready) begin
          m_ov = 1'b0;
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) publish();
      end else if (in_valid) begin
        p_err  = (i == 0) || (i > 11);
        p_r    = ref_data(int'(i), int'(mant), 1'b1);
        p_t    = ref_data(int'(i), int'(mant), 1'b0);
        m_wait = p_err ? 0 : int'(i) - 1;
        m_busy = 1'b1;
        if (m_wait == 0) publish();
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (!model_ok) return;
    check("in_ready",    int'(in_ready_r),  int'(!m_busy && !rst));
    check("in_ready_t",  int'(in_ready_t),  int'(!m_busy && !rst));
    check("out_valid",   int'(out_valid_r), int'(m_ov));
    check("out_valid_t", int'(out_valid_t), int'(m_ov));
    check("data",        int'(data_r),      m_data_r);
    check("data_t",      int'(data_t),      m_data_t);
    check("err",         int'(err_r),       int'(m_err));
    check("err_t",       int'(err_t),       int'(m_err));
  endtask

  // One clock: model steps with the DUT edge, outputs compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  // Directed transaction with literal expectations for value and latency.
  task automatic txn(input logic [4:0] ii, input logic [10:0] mm,
                     input int exp_r, input int exp_t, input int exp_err,
                     input int exp_lat, input int hold);
    int n;
    int lat;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while (!in_ready_r && n < 50) begin
      cycle();
      n++;
    end
    check("accept_ready", int'(in_ready_r), 1);
    in_valid = 1'b1;
    i        = ii;
    mant     = mm;
    cycle();
    // Inputs are ignored outside IDLE; scribble on them to prove it.
    in_valid = 1'b1;
    i        = 5'($urandom_range(0, 31));
    mant     = 11'($urandom);
    lat = 1;
    while (!out_valid_r && lat < 40) begin
      cycle();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("lit_data",   int'(data_r), exp_r);
    check("lit_data_t", int'(data_t), exp_t);
    check("lit_err",    int'(err_r),  exp_err);
    for (int k = 0; k < hold; k++) begin
      cycle();
      check("hold_data",  int'(data_r),     exp_r);
      check("hold_ready", int'(in_ready_r), 0);
      check("hold_valid", int'(out_valid_r), 1);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("post_valid", int'(out_valid_r), 0);
    check("post_ready", int'(in_ready_r),  1);
    check("post_data",  int'(data_r),      exp_r);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    i         = 5'd0;
    mant      = 11'd0;
    out_ready = 1'b0;
    cycle();
    cycle();
    check("rst_ready", int'(in_ready_r),  0);
    check("rst_valid", int'(out_valid_r), 0);
    check("rst_data",  int'(data_r),      0);
    check("rst_err",   int'(err_r),       0);
    rst = 1'b0;
    cycle();
    check("idle_ready", int'(in_ready_r), 1);

    txn(5'd1,  11'd2047, 2047, 2047, 0, 1,  0);
    txn(5'd4,  11'd1500, 188,  187,  0, 4,  0);
    txn(5'd11, 11'd1535, 1,    1,    0, 11, 0);
    txn(5'd11, 11'd1536, 2,    1,    0, 11, 0);
    txn(5'd0,  11'd777,  0,    0,    1, 1,  0);
    txn(5'd12, 11'd2047, 0,    0,    1, 1,  0);
    txn(5'd5,  11'd1000, 63,   62,   0, 5,  0);
    txn(5'd2,  11'd1000, 500,  500,  0, 2,  5);

    // Reset on the third shift cycle of an i=8 transaction.
    in_valid = 1'b1; i = 5'd8; mant = 11'd1999;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_valid", int'(out_valid_r), 0);
    check("abort_data",  int'(data_r),      0);
    check("abort_err",   int'(err_r),       0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("abort_quiet", int'(out_valid_r), 0);
    end
    txn(5'd3, 11'd1024, 256, 256, 0, 3, 0);

    // Randomized traffic, including illegal indices and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      i         = 5'($urandom_range(0, 13));
      mant      = 11'($urandom);
      out_ready = ($urandom_range(0, 4) < 2);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
